operacion_logica_seq: RTL and testbench

OPERACION_LOGICA_SEQ -- requirements
Module: operacion_logica_seq

---
 rtl/operacion_logica_seq_pkg.sv | 15 +
 rtl/operacion_logica_seq_slice.sv | 24 ++
 rtl/operacion_logica_seq.sv | 128 ++++++++++++
 tb/tb_operacion_logica_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operacion_logica_seq_pkg.sv
// Shared definitions for the sliced bitwise logic unit: op encodings and FSM states.
package operacion_logica_seq_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/operacion_logica_seq_slice.sv
// Combinational SLICE-bit bitwise operator; the top feeds it one operand slice per cycle.
module logica_slice
  import operacion_logica_seq_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/operacion_logica_seq.sv
// Sequential bitwise A op B, computed SLICE bits per cycle over NSLICES cycles.
// Define LOGICA_FLAGS_EN to add the registered zero and parity result flags.
module operacion_logica_seq
  import operacion_logica_seq_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef LOGICA_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLICE-1:0]   slice_y;
  logic               last_slice;

  assign last_slice = (cnt_q == CNT_W'(NSLICES - 1));

  logica_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_q[int'(cnt_q)*SLICE +: SLICE]),
    .b  (b_q[int'(cnt_q)*SLICE +: SLICE]),
    .op (op_q),
    .y  (slice_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter parks at 0 after the last slice so it never indexes past the operands.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = A;
      b_d   = B;
      op_d  = op;
      y_d   = '0;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      y_d[int'(cnt_q)*SLICE +: SLICE] = slice_y;
      cnt_d = last_slice ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Y         = y_q;
  end

`ifdef LOGICA_FLAGS_EN
  logic zero_q, zero_d;
  logic parity_q, parity_d;

  // Flags are captured from the completed result on the edge that enters DONE.
  always_comb begin
    zero_d   = zero_q;
    parity_d = parity_q;
    if (state_q == BUSY && last_slice) begin
      zero_d   = (y_d == '0);
      parity_d = ^y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_operacion_logica_seq.sv
// Directed self-checking bench for operacion_logica_seq (sliced WIDTH=6/SLICE=2 and single-slice SLICE=6).
module tb_operacion_logica_seq;
  import operacion_logica_seq_pkg::*;

  localparam int NSLICES = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] A, B, Y;
  logic [1:0] op;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       zero, parity;

  logic [5:0] a2, b2, y2;
  logic [1:0] op2;
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic       zero2, parity2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operacion_logica_seq #(.WIDTH(6), .SLICE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef LOGICA_FLAGS_EN
    ,
    .zero      (zero),
    .parity    (parity)
`endif
  );

  operacion_logica_seq #(.WIDTH(6), .SLICE(6)) dut_single (
    .clk       (clk),
    .rst       (rst),
    .A         (a2),
    .B         (b2),
    .op        (op2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .Y         (y2),
    .out_valid (out_valid2),
    .out_ready (out_ready2)
`ifdef LOGICA_FLAGS_EN
    ,
    .zero      (zero2),
    .parity    (parity2)
`endif
  );

`ifndef LOGICA_FLAGS_EN
  assign zero    = 1'b0;
  assign parity  = 1'b0;
  assign zero2   = 1'b0;
  assign parity2 = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A = '0; B = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
    a2 = '0; b2 = '0; op2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (Y !== 6'b000000) begin errors++; $display("[TB] FAIL reset_y: got %b expected 000000", Y); end
    checks++;
    if (in_ready2 !== 1'b1) begin errors++; $display("[TB] FAIL reset_single_in_ready: got %b expected 1", in_ready2); end
`ifdef LOGICA_FLAGS_EN
    checks++;
    if ({zero, parity} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {zero, parity}); end
`endif
  endtask

  task automatic test_ops();
    logic [5:0] ta [4] = '{6'b101010, 6'b111111, 6'b101010, 6'b110000};
    logic [5:0] tb [4] = '{6'b110011, 6'b000000, 6'b000101, 6'b101010};
    logic [1:0] to [4] = '{OP_XOR, OP_AND, OP_OR, OP_XNOR};
    logic [5:0] te [4] = '{6'b011001, 6'b000000, 6'b101111, 6'b100101};
    logic       tz [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       tp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cycles;
    for (int i = 0; i < 4; i++) begin
      A = ta[i]; B = tb[i]; op = to[i]; in_valid = 1'b1; out_ready = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ops_accept[%0d]: in_ready got %b expected 0", i, in_ready); end
      // Scramble operands after accept; the result must come from the latched copy.
      in_valid = 1'b0; A = ~ta[i]; B = ~tb[i]; op = ~to[i];
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 10) begin
        step();
        cycles++;
      end
      checks++;
      if (cycles != NSLICES) begin errors++; $display("[TB] FAIL ops_latency[%0d]: got %0d cycles expected %0d", i, cycles, NSLICES); end
      checks++;
      if (Y !== te[i]) begin errors++; $display("[TB] FAIL ops_result[%0d]: got %b expected %b", i, Y, te[i]); end
`ifdef LOGICA_FLAGS_EN
      checks++;
      if (zero !== tz[i]) begin errors++; $display("[TB] FAIL ops_zero[%0d]: got %b expected %b", i, zero, tz[i]); end
      checks++;
      if (parity !== tp[i]) begin errors++; $display("[TB] FAIL ops_parity[%0d]: got %b expected %b", i, parity, tp[i]); end
`else
      if (tz[i] !== tz[i] || tp[i] !== tp[i]) $display("[TB] flags disabled");
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL ops_release[%0d]: out_valid,in_ready got %b expected 01", i, {out_valid, in_ready}); end
    end
  endtask

  task automatic test_hold();
    int cycles;
    A = 6'b001100; B = 6'b010101; op = OP_OR; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 10) begin
      step();
      cycles++;
    end
    checks++;
    if (cycles != NSLICES) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected %0d", cycles, NSLICES); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A = 6'(i * 7 + 1);
      step();
      checks++;
      if ({out_valid, in_ready, Y} !== {2'b10, 6'b011101}) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: out_valid,in_ready,Y got %b expected 10011101", i, {out_valid, in_ready, Y});
      end
    end
    A = 6'b000011; B = 6'b000101; op = OP_AND; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL hold_release: got %b expected 01", {out_valid, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_pending_accept: in_ready got %b expected 0", in_ready); end
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 10) begin
      step();
      cycles++;
    end
    checks++;
    if (cycles != NSLICES || Y !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL hold_pending_result: got Y=%b after %0d cycles expected Y=000001 after %0d", Y, cycles, NSLICES);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    A = 6'b111111; B = 6'b101010; op = OP_OR; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, Y} !== {2'b10, 6'b000000}) begin
      errors++;
      $display("[TB] FAIL rst_busy_state: in_ready,out_valid,Y got %b expected 10000000", {in_ready, out_valid, Y});
    end
`ifdef LOGICA_FLAGS_EN
    checks++;
    if ({zero, parity} !== 2'b00) begin errors++; $display("[TB] FAIL rst_busy_flags: got %b expected 00", {zero, parity}); end
`endif
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL rst_busy_no_pulse: got %0d out_valid cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_y [2] = '{6'b010101, 6'b100000};
    int acc_at [2];
    int n_acc, n_res;
    logic will;
    acc_at[0] = 0; acc_at[1] = 0;
    n_acc = 0; n_res = 0;
    out_ready = 1'b1;
    A = 6'b000111; B = 6'b010010; op = OP_XOR; in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      will = in_ready && in_valid;
      step();
      if (will && n_acc < 2) begin
        acc_at[n_acc] = i;
        n_acc++;
        if (n_acc == 1) begin
          A = 6'b111000; B = 6'b100001; op = OP_AND;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        if (n_res < 2) begin
          checks++;
          if (Y !== exp_y[n_res]) begin errors++; $display("[TB] FAIL b2b_result[%0d]: got %b expected %b", n_res, Y, exp_y[n_res]); end
        end
        n_res++;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (n_acc != 2 || n_res != 2) begin errors++; $display("[TB] FAIL b2b_counts: accepts %0d results %0d expected 2 and 2", n_acc, n_res); end
    // Accept edges sit NSLICES+2 apart: NSLICES+1 full BUSY/DONE cycles lie between them.
    checks++;
    if (acc_at[1] - acc_at[0] != NSLICES + 2) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got %0d edges expected %0d", acc_at[1] - acc_at[0], NSLICES + 2);
    end
  endtask

  task automatic test_single_slice();
    a2 = 6'b010101; b2 = 6'b010101; op2 = OP_XNOR; in_valid2 = 1'b1; out_ready2 = 1'b0;
    step();
    in_valid2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0) begin errors++; $display("[TB] FAIL single_early: out_valid got %b expected 0", out_valid2); end
    step();
    checks++;
    if (out_valid2 !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: out_valid got %b expected 1", out_valid2); end
    checks++;
    if (y2 !== 6'b111111) begin errors++; $display("[TB] FAIL single_result: got %b expected 111111", y2); end
`ifdef LOGICA_FLAGS_EN
    checks++;
    if ({zero2, parity2} !== 2'b00) begin errors++; $display("[TB] FAIL single_flags: got %b expected 00", {zero2, parity2}); end
`endif
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    checks++;
    if (in_ready2 !== 1'b1) begin errors++; $display("[TB] FAIL single_release: in_ready got %b expected 1", in_ready2); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_reset_mid_busy();
    test_back_to_back();
    test_single_slice();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
